// File: rtl/pid_dispatch_pkg.sv
// Shared definitions for the pid_filter dispatcher: config register map and decode.
package pid_dispatch_pkg;

  localparam int unsigned disp_chan_en_addr = 32'h0000_0040;
  localparam int unsigned disp_ovr_clr_addr = 32'h0000_0041;

  typedef enum logic [1:0] {
    CFG_NONE    = 2'd0,
    CFG_CHAN_EN = 2'd1,
    CFG_OVR_CLR = 2'd2
  } cfg_op_e;

  // Map a config write address onto the dispatcher operation it selects.
  function automatic cfg_op_e decode_cfg(input int unsigned addr);
    cfg_op_e op;
    op = CFG_NONE;
    if (addr == disp_chan_en_addr) op = CFG_CHAN_EN;
    else if (addr == disp_ovr_clr_addr) op = CFG_OVR_CLR;
    return op;
  endfunction

endpackage

// File: rtl/pid_dispatch_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 8,
  localparam int unsigned W_IDX = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [W_IDX-1:0] ptr_i,
  output logic             gnt_vld_o,
  output logic [W_IDX-1:0] gnt_idx_o
);

  logic [W_IDX-1:0] cand;

  // Scan from farthest to nearest so the nearest requester after ptr_i is kept.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    cand      = '0;
    for (int unsigned off = N; off > 0; off--) begin
      cand = W_IDX'((32'(ptr_i) + off) % N);
      if (req_i[cand]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/pid_dispatch.sv
// Per-channel sample buffer and hazard-free round-robin issue stage feeding pid_filter.
module pid_dispatch
  import pid_dispatch_pkg::*;
#(
  parameter int unsigned W_CHAN    = 5,
  parameter int unsigned N_CHAN    = 8,
  parameter int unsigned W_DIN     = 18,
  parameter int unsigned HAZ_CYC   = 6,
  parameter int unsigned W_WR_ADDR = 16,
  parameter int unsigned W_WR_CHAN = 16,
  parameter int unsigned W_WR_DATA = 48
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    dv_in,
  input  logic [W_CHAN-1:0]       chan_in,
  input  logic signed [W_DIN-1:0] data_in,
  input  logic                    wr_en,
  input  logic [W_WR_ADDR-1:0]    wr_addr,
  input  logic [W_WR_CHAN-1:0]    wr_chan,
  input  logic [W_WR_DATA-1:0]    wr_data,
  output logic                    dv_out,
  output logic [W_CHAN-1:0]       chan_out,
  output logic signed [W_DIN-1:0] data_out,
  output logic [N_CHAN-1:0]       ovr_out
);

  localparam int unsigned W_IDX  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int unsigned W_COOL = (HAZ_CYC > 1) ? $clog2(HAZ_CYC) : 1;

  logic [N_CHAN-1:0]       pend_q, pend_d;
  logic [N_CHAN-1:0]       en_q, en_d;
  logic [N_CHAN-1:0]       ovr_q, ovr_d;
  logic signed [W_DIN-1:0] buf_q [N_CHAN];
  logic signed [W_DIN-1:0] buf_d [N_CHAN];
  logic [W_COOL-1:0]       cool_q [N_CHAN];
  logic [W_COOL-1:0]       cool_d [N_CHAN];
  logic [W_IDX-1:0]        ptr_q, ptr_d;
  logic                    dv_q, dv_d;
  logic [W_CHAN-1:0]       chan_q, chan_d;
  logic signed [W_DIN-1:0] data_q, data_d;

  logic [N_CHAN-1:0] elig_c;
  logic              gnt_vld_c;
  logic [W_IDX-1:0]  gnt_idx_c;
  logic              cap_ok_c;
  logic [W_IDX-1:0]  cap_idx_c;
  logic [W_IDX-1:0]  cfg_idx_c;
  cfg_op_e           cfg_op_c;
  logic              unused_wr_data;

  assign unused_wr_data = ^wr_data[W_WR_DATA-1:1];

  // Input and config decode; out-of-range channels never touch state.
  always_comb begin
    cap_idx_c = W_IDX'(chan_in);
    cfg_idx_c = W_IDX'(wr_chan);
    cap_ok_c  = dv_in && (32'(chan_in) < N_CHAN) && en_q[cap_idx_c];
    cfg_op_c  = CFG_NONE;
    if (wr_en && (32'(wr_chan) < N_CHAN)) cfg_op_c = decode_cfg(32'(wr_addr));
  end

  always_comb begin
    elig_c = '0;
    for (int unsigned c = 0; c < N_CHAN; c++) begin
      elig_c[c] = pend_q[c] && en_q[c] && (cool_q[c] == '0);
    end
  end

  rr_arbiter #(.N(N_CHAN)) u_arb (
    .req_i     (elig_c),
    .ptr_i     (ptr_q),
    .gnt_vld_o (gnt_vld_c),
    .gnt_idx_o (gnt_idx_c)
  );

  // Next state: issue, then capture, then enable writes (disable drops the pending sample).
  always_comb begin
    pend_d = pend_q;
    en_d   = en_q;
    ovr_d  = ovr_q;
    buf_d  = buf_q;
    cool_d = cool_q;
    ptr_d  = ptr_q;
    dv_d   = 1'b0;
    chan_d = chan_q;
    data_d = data_q;

    for (int unsigned c = 0; c < N_CHAN; c++) begin
      if (cool_q[c] != '0) cool_d[c] = cool_q[c] - W_COOL'(1);
    end

    if (gnt_vld_c) begin
      dv_d              = 1'b1;
      chan_d            = W_CHAN'(gnt_idx_c);
      data_d            = buf_q[gnt_idx_c];
      pend_d[gnt_idx_c] = 1'b0;
      cool_d[gnt_idx_c] = W_COOL'(HAZ_CYC - 1);
      ptr_d             = gnt_idx_c;
    end

    if (cfg_op_c == CFG_OVR_CLR) ovr_d[cfg_idx_c] = 1'b0;

    if (cap_ok_c) begin
      buf_d[cap_idx_c] = data_in;
      if (pend_q[cap_idx_c] && !(gnt_vld_c && (gnt_idx_c == cap_idx_c))) begin
        ovr_d[cap_idx_c] = 1'b1;
      end
      pend_d[cap_idx_c] = 1'b1;
    end

    if (cfg_op_c == CFG_CHAN_EN) begin
      en_d[cfg_idx_c] = wr_data[0];
      if (!wr_data[0]) pend_d[cfg_idx_c] = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend_q <= '0;
      en_q   <= '0;
      ovr_q  <= '0;
      buf_q  <= '{default: '0};
      cool_q <= '{default: '0};
      ptr_q  <= W_IDX'(N_CHAN - 1);
      dv_q   <= 1'b0;
      chan_q <= '0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      en_q   <= en_d;
      ovr_q  <= ovr_d;
      buf_q  <= buf_d;
      cool_q <= cool_d;
      ptr_q  <= ptr_d;
      dv_q   <= dv_d;
      chan_q <= chan_d;
      data_q <= data_d;
    end
  end

  assign dv_out   = dv_q;
  assign chan_out = chan_q;
  assign data_out = data_q;
  assign ovr_out  = ovr_q;

endmodule

// File: tb/tb_pid_dispatch.sv
// Directed vector bench for pid_dispatch: issue order, latency, cooldown, overrun and reset.
module tb_pid_dispatch;
  import pid_dispatch_pkg::*;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic                dv_in;
  logic [4:0]          chan_in;
  logic signed [17:0]  data_in;
  logic                wr_en;
  logic [15:0]         wr_addr;
  logic [15:0]         wr_chan;
  logic [47:0]         wr_data;
  logic                dv_out;
  logic [4:0]          chan_out;
  logic signed [17:0]  data_out;
  logic [7:0]          ovr_out;

  always #5 clk_in = ~clk_in;

  pid_dispatch dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .dv_in    (dv_in),
    .chan_in  (chan_in),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_chan  (wr_chan),
    .wr_data  (wr_data),
    .dv_out   (dv_out),
    .chan_out (chan_out),
    .data_out (data_out),
    .ovr_out  (ovr_out)
  );

  typedef struct {
    logic               rst;
    logic               dv;
    logic [4:0]         ch;
    logic signed [17:0] d;
    logic               we;
    logic [15:0]        wa;
    logic [15:0]        wc;
    logic [47:0]        wd;
    logic               e_dv;
    logic [4:0]         e_ch;
    logic signed [17:0] e_d;
    logic [7:0]         e_ovr;
    logic               chk_cd;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   split;

  function automatic vec_t rrow(input logic rst, input logic dv, input int ch, input int d,
                                input logic we, input int wa, input int wc, input int wd,
                                input logic edv, input int ech, input int ed, input int eovr);
    vec_t r;
    r.rst    = rst;
    r.dv     = dv;
    r.ch     = 5'(ch);
    r.d      = 18'(d);
    r.we     = we;
    r.wa     = 16'(wa);
    r.wc     = 16'(wc);
    r.wd     = 48'(wd);
    r.e_dv   = edv;
    r.e_ch   = 5'(ech);
    r.e_d    = 18'(ed);
    r.e_ovr  = 8'(eovr);
    r.chk_cd = edv | rst;
    return r;
  endfunction

  function automatic vec_t c0(input int ch, input int d, input int ov);
    return rrow(1'b0, 1'b1, ch, d, 1'b0, 0, 0, 0, 1'b0, 0, 0, ov);
  endfunction
  function automatic vec_t ci(input int ch, input int d, input int ich, input int id, input int ov);
    return rrow(1'b0, 1'b1, ch, d, 1'b0, 0, 0, 0, 1'b1, ich, id, ov);
  endfunction
  function automatic vec_t iss(input int ich, input int id, input int ov);
    return rrow(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b1, ich, id, ov);
  endfunction
  function automatic vec_t idl(input int ov);
    return rrow(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 0, 0, ov);
  endfunction
  function automatic vec_t cen(input int ch, input int v, input int ov);
    return rrow(1'b0, 1'b0, 0, 0, 1'b1, int'(disp_chan_en_addr), ch, v, 1'b0, 0, 0, ov);
  endfunction
  function automatic vec_t cclr(input int ch, input int ov);
    return rrow(1'b0, 1'b0, 0, 0, 1'b1, int'(disp_ovr_clr_addr), ch, 0, 1'b0, 0, 0, ov);
  endfunction

  task automatic chk(input string what, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", what, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_in  = v.rst;
    dv_in   = v.dv;
    chan_in = v.ch;
    data_in = v.d;
    wr_en   = v.we;
    wr_addr = v.wa;
    wr_chan = v.wc;
    wr_data = v.wd;
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk_in);
      drive(vecs[i]);
      @(posedge clk_in);
      #1;
      chk("dv_out", i, 64'(dv_out), 64'(vecs[i].e_dv));
      if (vecs[i].chk_cd) begin
        chk("chan_out", i, 64'(chan_out), 64'(vecs[i].e_ch));
        chk("data_out", i, 64'(data_out), 64'(vecs[i].e_d));
      end
      chk("ovr_out", i, 64'(ovr_out), 64'(vecs[i].e_ovr));
    end
  endtask

  initial begin
    rst_in  = 1'b1;
    dv_in   = 1'b0;
    chan_in = '0;
    data_in = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_chan = '0;
    wr_data = '0;

    // Reset, single-sample latency, in-order burst, disable clearing pending.
    vecs.push_back(rrow(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0));
    vecs.push_back(cen(0, 1, 0));
    vecs.push_back(c0(0, 100, 0));
    vecs.push_back(iss(0, 100, 0));
    vecs.push_back(idl(0));
    vecs.push_back(cen(1, 1, 0));
    vecs.push_back(cen(2, 1, 0));
    vecs.push_back(idl(0));
    vecs.push_back(idl(0));
    vecs.push_back(c0(0, 1, 0));
    vecs.push_back(ci(1, 2, 0, 1, 0));
    vecs.push_back(ci(2, 3, 1, 2, 0));
    vecs.push_back(iss(2, 3, 0));
    vecs.push_back(idl(0));
    vecs.push_back(c0(1, 5, 0));
    vecs.push_back(cen(1, 0, 0));
    vecs.push_back(c0(1, 6, 0));
    vecs.push_back(cen(1, 1, 0));
    vecs.push_back(idl(0));
    vecs.push_back(idl(0));
    // Round-robin over all eight channels with wrap back to ch0.
    for (int c = 3; c < 8; c++) vecs.push_back(cen(c, 1, 0));
    vecs.push_back(c0(7, 17, 0));
    vecs.push_back(ci(0, 20, 7, 17, 0));
    vecs.push_back(ci(7, 27, 0, 20, 0));
    vecs.push_back(c0(1, 21, 0));
    vecs.push_back(ci(2, 22, 1, 21, 0));
    vecs.push_back(ci(3, 23, 2, 22, 0));
    vecs.push_back(ci(4, 24, 3, 23, 0));
    vecs.push_back(ci(5, 25, 4, 24, 0));
    vecs.push_back(ci(6, 26, 5, 25, 0));
    vecs.push_back(ci(0, 30, 6, 26, 0));
    vecs.push_back(ci(1, 31, 7, 27, 0));
    vecs.push_back(iss(0, 30, 0));
    vecs.push_back(iss(1, 31, 0));
    vecs.push_back(idl(0));
    vecs.push_back(idl(0));
    vecs.push_back(idl(0));
    // Out-of-range sample and config channel must not alias onto ch0.
    vecs.push_back(c0(8, 77, 0));
    vecs.push_back(rrow(1'b0, 1'b0, 0, 0, 1'b1, int'(disp_chan_en_addr), 8, 0, 1'b0, 0, 0, 0));
    vecs.push_back(c0(0, 78, 0));
    vecs.push_back(iss(0, 78, 0));
    vecs.push_back(idl(0));
    split = vecs.size();
    // Overrun clear, reset mid-operation, set-beats-clear.
    vecs.push_back(cclr(3, 0));
    vecs.push_back(c0(2, 50, 0));
    vecs.push_back(ci(2, 51, 2, 50, 0));
    vecs.push_back(c0(2, 52, 4));
    vecs.push_back(c0(5, 55, 4));
    vecs.push_back(rrow(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0));
    for (int k = 0; k < 8; k++) vecs.push_back(idl(0));
    vecs.push_back(cen(2, 1, 0));
    vecs.push_back(cen(5, 1, 0));
    for (int k = 0; k < 7; k++) vecs.push_back(idl(0));
    vecs.push_back(c0(2, 60, 0));
    vecs.push_back(ci(2, 61, 2, 60, 0));
    vecs.push_back(rrow(1'b0, 1'b1, 2, 62, 1'b1, int'(disp_ovr_clr_addr), 2, 0, 1'b0, 0, 0, 4));
    vecs.push_back(cclr(2, 0));
    vecs.push_back(idl(0));
    vecs.push_back(idl(0));
    vecs.push_back(idl(0));
    vecs.push_back(iss(2, 62, 0));
    vecs.push_back(idl(0));

    run_vec(0, split);

    // Back-to-back samples on ch3: issue every 6 cycles with the newest sample.
    for (int i = 0; i < 26; i++) begin
      logic               e_dv;
      logic [4:0]         e_ch;
      logic signed [17:0] e_d;
      logic [7:0]         e_ovr;
      @(negedge clk_in);
      rst_in  = 1'b0;
      wr_en   = 1'b0;
      dv_in   = (i <= 19);
      chan_in = 5'd3;
      data_in = 18'(10 + i);
      @(posedge clk_in);
      #1;
      e_dv  = (i >= 1) && (((i - 1) % 6) == 0);
      if (i == 0) begin
        e_ch = 5'd0;
        e_d  = 18'sd78;
      end else begin
        e_ch = 5'd3;
        e_d  = (i >= 25) ? 18'sd29 : 18'(10 + 6 * ((i - 1) / 6));
      end
      e_ovr = (i >= 2) ? 8'h08 : 8'h00;
      chk("t3_dv_out", i, 64'(dv_out), 64'(e_dv));
      chk("t3_chan_out", i, 64'(chan_out), 64'(e_ch));
      chk("t3_data_out", i, 64'(data_out), 64'(e_d));
      chk("t3_ovr_out", i, 64'(ovr_out), 64'(e_ovr));
    end

    run_vec(split, vecs.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
